// File: rtl/lab5_uta_pkg.sv
// Shared encodings for the lab5_uta instruction classifier.
package lab5_uta_pkg;

    localparam logic [1:0] INS_DATA   = 2'b00;
    localparam logic [1:0] INS_MEM    = 2'b01;
    localparam logic [1:0] INS_BRANCH = 2'b10;
    localparam logic [1:0] INS_UNSUP  = 2'b11;

    localparam logic [2:0] DP_AND   = 3'd0;
    localparam logic [2:0] DP_EOR   = 3'd1;
    localparam logic [2:0] DP_SUB   = 3'd2;
    localparam logic [2:0] DP_ADD   = 3'd3;
    localparam logic [2:0] DP_ORR   = 3'd4;
    localparam logic [2:0] DP_MOV   = 3'd5;
    localparam logic [2:0] DP_CMP   = 3'd6;
    localparam logic [2:0] DP_OTHER = 3'd7;

    // Raw opcode field values, bits [24:21]
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_CMP = 4'b1010;

    localparam logic [1:0] MEM_STR  = 2'b00;
    localparam logic [1:0] MEM_LDR  = 2'b01;
    localparam logic [1:0] MEM_STRB = 2'b10;
    localparam logic [1:0] MEM_LDRB = 2'b11;

    localparam logic [1:0] BR_B  = 2'b00;
    localparam logic [1:0] BR_BL = 2'b01;
    localparam logic [1:0] BR_BX = 2'b10;

    localparam logic [23:0] BX_MATCH = 24'h12FFF1;

    typedef struct packed {
        logic [1:0] ins_type;
        logic [2:0] data_ins_type;
        logic [1:0] mem_ins_type;
        logic [1:0] branch_ins_type;
    } decode_t;

endpackage

// File: rtl/lab5_uta_decode.sv
// Combinational classifier: instruction word to class and sub-type fields.
module lab5_uta_decode
    import lab5_uta_pkg::*;
(
    input  logic [31:0] instruction,
    output logic [1:0]  ins_type,
    output logic [2:0]  data_ins_type,
    output logic [1:0]  mem_ins_type,
    output logic [1:0]  branch_ins_type
);

    // Condition field plays no part in classification.
    logic unused_cond;
    assign unused_cond = ^instruction[31:28];

    always_comb begin
        ins_type        = INS_UNSUP;
        data_ins_type   = DP_AND;
        mem_ins_type    = MEM_STR;
        branch_ins_type = BR_B;
        // BX sits inside the data-processing encoding space, so it must win first.
        if (instruction[27:4] == BX_MATCH) begin
            ins_type        = INS_BRANCH;
            branch_ins_type = BR_BX;
        end else if (instruction[27:25] == 3'b101) begin
            ins_type        = INS_BRANCH;
            branch_ins_type = {1'b0, instruction[24]};
        end else if (instruction[27:26] == 2'b00) begin
            ins_type = INS_DATA;
            case (instruction[24:21])
                OP_AND:  data_ins_type = DP_AND;
                OP_EOR:  data_ins_type = DP_EOR;
                OP_SUB:  data_ins_type = DP_SUB;
                OP_ADD:  data_ins_type = DP_ADD;
                OP_ORR:  data_ins_type = DP_ORR;
                OP_MOV:  data_ins_type = DP_MOV;
                OP_CMP:  data_ins_type = DP_CMP;
                default: data_ins_type = DP_OTHER;
            endcase
        end else if (instruction[27:26] == 2'b01) begin
            ins_type     = INS_MEM;
            mem_ins_type = {instruction[22], instruction[20]};
        end
    end

endmodule

// File: rtl/lab5_uta.sv
// Registered instruction classifier: one decode per clock, one cycle latency.
module lab5_uta
    import lab5_uta_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    output logic [1:0]  ins_type,
    output logic [2:0]  data_ins_type,
    output logic [1:0]  mem_ins_type,
    output logic [1:0]  branch_ins_type,
    output logic        valid
);

    decode_t dec;
    decode_t dec_q;

    lab5_uta_decode u_decode (
        .instruction     (instruction),
        .ins_type        (dec.ins_type),
        .data_ins_type   (dec.data_ins_type),
        .mem_ins_type    (dec.mem_ins_type),
        .branch_ins_type (dec.branch_ins_type)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dec_q <= '0;
            valid <= 1'b0;
        end else begin
            dec_q <= dec;
            valid <= 1'b1;
        end
    end

    assign ins_type        = dec_q.ins_type;
    assign data_ins_type   = dec_q.data_ins_type;
    assign mem_ins_type    = dec_q.mem_ins_type;
    assign branch_ins_type = dec_q.branch_ins_type;

endmodule

// File: tb/tb_lab5_uta.sv
// Table-driven scoreboard bench for lab5_uta with hand-written reset sequences.
module tb_lab5_uta;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instruction = 32'h034112EA;
    logic [1:0]  ins_type;
    logic [2:0]  data_ins_type;
    logic [1:0]  mem_ins_type;
    logic [1:0]  branch_ins_type;
    logic        valid;

    lab5_uta dut (
        .clk             (clk),
        .reset           (reset),
        .instruction     (instruction),
        .ins_type        (ins_type),
        .data_ins_type   (data_ins_type),
        .mem_ins_type    (mem_ins_type),
        .branch_ins_type (branch_ins_type),
        .valid           (valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic [1:0]  t;
        logic [2:0]  d;
        logic [1:0]  m;
        logic [1:0]  b;
    } vec_t;

    vec_t       vecs[$];
    logic [9:0] sb_q[$];
    logic [31:0] sb_ins_q[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [9:0] actual();
        return {valid, ins_type, data_ins_type, mem_ins_type, branch_ins_type};
    endfunction

    function automatic logic [9:0] expect_of(vec_t v);
        return {1'b1, v.t, v.d, v.m, v.b};
    endfunction

    task automatic check(string name, logic [31:0] ins, logic [9:0] act, logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s ins=%h got {v,t,d,m,b}=%b want %b", name, ins, act, exp);
        end
    endtask

    task automatic pop_check(string name);
        logic [9:0]  e;
        logic [31:0] i;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            i = sb_ins_q.pop_front();
            check(name, i, actual(), e);
        end
    endtask

    // Compare whatever the previous edge produced, then drive the next word.
    task automatic step(logic [31:0] ins, logic [9:0] exp);
        @(negedge clk);
        if (sb_q.size() != 0) pop_check("vec");
        instruction = ins;
        sb_q.push_back(exp);
        sb_ins_q.push_back(ins);
    endtask

    initial begin
        vecs.push_back('{32'h03FAD394, 2'b00, 3'b111, 2'b00, 2'b00}); // MVN -> other
        vecs.push_back('{32'h27CDA5E8, 2'b01, 3'b000, 2'b10, 2'b00}); // STRB
        vecs.push_back('{32'hE5900000, 2'b01, 3'b000, 2'b01, 2'b00}); // LDR
        vecs.push_back('{32'h1B459795, 2'b10, 3'b000, 2'b00, 2'b01}); // BL
        vecs.push_back('{32'hEA000000, 2'b10, 3'b000, 2'b00, 2'b00}); // B
        vecs.push_back('{32'h034112EA, 2'b00, 3'b110, 2'b00, 2'b00}); // CMP
        vecs.push_back('{32'hE12FFF1E, 2'b10, 3'b000, 2'b00, 2'b10}); // BX
        vecs.push_back('{32'hEF000000, 2'b11, 3'b000, 2'b00, 2'b00}); // [27:26]=11
        vecs.push_back('{32'hE8000000, 2'b11, 3'b000, 2'b00, 2'b00}); // [27:25]=100
        vecs.push_back('{32'hE0000000, 2'b00, 3'b000, 2'b00, 2'b00}); // AND
        vecs.push_back('{32'hE0200000, 2'b00, 3'b001, 2'b00, 2'b00}); // EOR
        vecs.push_back('{32'hE0400000, 2'b00, 3'b010, 2'b00, 2'b00}); // SUB
        vecs.push_back('{32'hE0800000, 2'b00, 3'b011, 2'b00, 2'b00}); // ADD
        vecs.push_back('{32'hE1800000, 2'b00, 3'b100, 2'b00, 2'b00}); // ORR
        vecs.push_back('{32'hE3B00000, 2'b00, 3'b101, 2'b00, 2'b00}); // MOV, I=1 S=1
        vecs.push_back('{32'hE1000000, 2'b00, 3'b111, 2'b00, 2'b00}); // TST -> other
        vecs.push_back('{32'hE12FFF2E, 2'b00, 3'b111, 2'b00, 2'b00}); // BX near-miss
        vecs.push_back('{32'hE5D00000, 2'b01, 3'b000, 2'b11, 2'b00}); // LDRB
        vecs.push_back('{32'hE5800000, 2'b01, 3'b000, 2'b00, 2'b00}); // STR

        // Reset held: outputs zero before and across edges.
        #1 check("reset_initial", instruction, actual(), 10'b0);
        repeat (3) begin
            @(negedge clk);
            check("reset_held", instruction, actual(), 10'b0);
        end
        reset = 1'b0;

        foreach (vecs[i]) step(vecs[i].ins, expect_of(vecs[i]));
        @(negedge clk);
        pop_check("vec_last");

        // Back-to-back then asynchronous reset mid-stream.
        step(32'h03FAD394, expect_of(vecs[0]));
        step(32'h27CDA5E8, expect_of(vecs[1]));
        @(posedge clk);
        #2 pop_check("b2b_before_reset");
        reset = 1'b1;
        #1 check("async_clear", instruction, actual(), 10'b0);
        @(negedge clk);
        instruction = 32'h1B459795;
        @(negedge clk);
        check("reset_mid_held", instruction, actual(), 10'b0);
        reset = 1'b0;
        sb_q.push_back(expect_of(vecs[3]));
        sb_ins_q.push_back(instruction);
        step(32'h034112EA, expect_of(vecs[5]));
        step(32'hEF000000, expect_of(vecs[7]));
        @(negedge clk);
        pop_check("b2b_tail");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

endmodule
